// File: rtl/ctrl_part4.sv
// ctrl_part4: control FSM for the 8x8 matrix-vector multiplier datapath.
// Loads 64 W words and 8 x words, runs eight 8-term MAC passes (one per row)
// and hands each row result to a consumer over a valid/ready handshake.
// Ports:
//   clk, rst (async, active-low)                  clock and reset
//   start, reuse_w                                begin an operation, optionally skipping the W load
//   data_valid / in_ready                         input word handshake (data bus bypasses this block)
//   addr_x, wr_en_x, addr_w, wr_en_w              datapath memory addresses and write enables
//   clear_acc, en_acc                             datapath accumulator controls
//   result_valid / result_ready, row_idx          result handshake and row of the current result
//   busy, done                                    not-idle flag, one-cycle completion pulse
module ctrl_part4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       reuse_w,
    input  logic       data_valid,
    output logic       in_ready,
    output logic [2:0] addr_x,
    output logic       wr_en_x,
    output logic [5:0] addr_w,
    output logic       wr_en_w,
    output logic       clear_acc,
    output logic       en_acc,
    output logic       result_valid,
    input  logic       result_ready,
    output logic [2:0] row_idx,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_CLEAR, S_MAC, S_DRAIN, S_OUT} state_t;

    state_t     r_state, w_next;
    logic [5:0] r_wcnt;
    logic [2:0] r_xcnt, r_row, r_k;
    logic       r_w_loaded, r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = (reuse_w && r_w_loaded) ? S_LOAD_X : S_LOAD_W;
            S_LOAD_W: if (data_valid && r_wcnt == 6'd63) w_next = S_LOAD_X;
            S_LOAD_X: if (data_valid && r_xcnt == 3'd7) w_next = S_CLEAR;
            S_CLEAR:  w_next = S_MAC;
            S_MAC:    if (r_k == 3'd7) w_next = S_DRAIN;
            S_DRAIN:  w_next = S_OUT;
            S_OUT:    if (result_ready) w_next = (r_row == 3'd7) ? S_IDLE : S_CLEAR;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt     <= '0;
            r_xcnt     <= '0;
            r_row      <= '0;
            r_k        <= '0;
            r_w_loaded <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == S_OUT) && result_ready && (r_row == 3'd7);
            // Counters wrap naturally at their widths, so a full load leaves them at 0.
            if (r_state == S_LOAD_W && data_valid) begin
                r_wcnt <= r_wcnt + 6'd1;
                if (r_wcnt == 6'd63) r_w_loaded <= 1'b1;
            end
            if (r_state == S_LOAD_X && data_valid) begin
                r_xcnt <= r_xcnt + 3'd1;
                if (r_xcnt == 3'd7) r_row <= '0;
            end
            if (r_state == S_CLEAR) r_k <= 3'd1;
            if (r_state == S_MAC && r_k != 3'd7) r_k <= r_k + 3'd1;
            if (r_state == S_OUT && result_ready && r_row != 3'd7) r_row <= r_row + 3'd1;
        end
    end

    // DRAIN and OUT keep the addresses of the final MAC cycle (column 7).
    always_comb begin
        in_ready     = (r_state == S_LOAD_W) || (r_state == S_LOAD_X);
        wr_en_w      = (r_state == S_LOAD_W) && data_valid;
        wr_en_x      = (r_state == S_LOAD_X) && data_valid;
        addr_w       = (r_state == S_LOAD_W) ? r_wcnt :
                       (r_state == S_CLEAR)  ? {r_row, 3'd0} :
                       (r_state == S_MAC)    ? {r_row, r_k} :
                       (r_state == S_DRAIN || r_state == S_OUT) ? {r_row, 3'd7} : 6'd0;
        addr_x       = (r_state == S_LOAD_X) ? r_xcnt :
                       (r_state == S_MAC)    ? r_k :
                       (r_state == S_DRAIN || r_state == S_OUT) ? 3'd7 : 3'd0;
        clear_acc    = (r_state == S_CLEAR);
        en_acc       = (r_state == S_MAC) || (r_state == S_DRAIN);
        result_valid = (r_state == S_OUT);
        row_idx      = (r_state == S_OUT) ? r_row : 3'd0;
        busy         = (r_state != S_IDLE);
        done         = r_done;
    end
endmodule

// File: tb/tb_ctrl_part4.sv
// tb_ctrl_part4: randomized bench for ctrl_part4 with a behavioural datapath and matrix-vector reference.
module tb_ctrl_part4;
    logic       clk = 1'b0, rst = 1'b0;
    logic       start = 1'b0, reuse_w = 1'b0, data_valid = 1'b0, result_ready = 1'b1;
    logic       in_ready, wr_en_x, wr_en_w, clear_acc, en_acc, result_valid, busy, done;
    logic [2:0] addr_x, row_idx;
    logic [5:0] addr_w;

    ctrl_part4 dut (
        .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w), .data_valid(data_valid),
        .in_ready(in_ready), .addr_x(addr_x), .wr_en_x(wr_en_x), .addr_w(addr_w), .wr_en_w(wr_en_w),
        .clear_acc(clear_acc), .en_acc(en_acc), .result_valid(result_valid),
        .result_ready(result_ready), .row_idx(row_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, base = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    localparam longint SMAX = (64'sd1 <<< 27) - 1;
    localparam longint SMIN = -(64'sd1 <<< 27);

    function automatic longint sat(input longint v);
        return (v > SMAX) ? SMAX : (v < SMIN) ? SMIN : v;
    endfunction

    // Reference operands (row-major W) and the mathematical result per row.
    logic signed [13:0] wref [64];
    logic signed [13:0] xref [8];

    function automatic longint exp_row(input int r);
        longint a = 0;
        for (int c = 0; c < 8; c++) a = sat(a + longint'(wref[r*8+c]) * longint'(xref[c]));
        return a;
    endfunction

    // Behavioural datapath: synchronous-read memories, product of registered reads, saturating accumulator.
    logic signed [13:0] src_q [$];
    logic signed [13:0] wmem [64];
    logic signed [13:0] xmem [8];
    logic signed [13:0] rd_w = 0, rd_x = 0;
    longint acc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            if (data_valid && in_ready && src_q.size() > 0) begin
                if (wr_en_w) wmem[addr_w] <= src_q[0];
                if (wr_en_x) xmem[addr_x] <= src_q[0];
                void'(src_q.pop_front());
            end
            rd_w <= wmem[addr_w];
            rd_x <= xmem[addr_x];
            if (clear_acc) acc <= 0;
            else if (en_acc) acc <= sat(acc + longint'(rd_w) * longint'(rd_x));
        end
    end

    // Monitor, sampled on the falling edge.
    int nw, nx, en_cnt, clr_cnt, done_rel;
    bit done_seen, hold;
    logic [2:0] hold_row;
    longint hold_acc;
    int res_row [$];
    longint res_val [$];
    int res_rel [$];

    always @(negedge clk) begin
        if (rst) begin
            if (busy) chk("xfer", {63'd0, wr_en_w | wr_en_x}, {63'd0, data_valid & in_ready});
            if (wr_en_w) begin chk("w_addr", addr_w, nw % 64); nw++; end
            if (wr_en_x) begin chk("x_addr", addr_x, nx % 8); nx++; end
            if (en_acc) en_cnt++;
            if (clear_acc) clr_cnt++;
            if (hold) begin
                chk("hold_valid", result_valid, 1);
                chk("hold_row", row_idx, hold_row);
                chk("hold_quiet", {clear_acc, en_acc}, 0);
                chk("hold_acc", acc, hold_acc);
            end
            hold     = result_valid && !result_ready;
            hold_row = row_idx;
            hold_acc = acc;
            if (result_valid && result_ready) begin
                chk("en_per_row", en_cnt, 8);
                chk("clr_per_row", clr_cnt, 1);
                en_cnt = 0;
                clr_cnt = 0;
                res_row.push_back(int'(row_idx));
                res_val.push_back(acc);
                res_rel.push_back(cyc - base);
            end
            if (done) begin
                chk("done_busy", busy, 0);
                done_rel  = cyc - base;
                done_seen = 1;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {in_ready, addr_x, wr_en_x, addr_w, wr_en_w, clear_acc, en_acc,
                  result_valid, row_idx, busy, done}, 0);
    endtask

    // One operation. vmode: 0 = data_valid held, 1 = alternating, 2 = random.
    task automatic run_op(input bit reuse, input bit exp_skip, input int vmode,
                          input int stall_row, input bit timed, input bit abort);
        int stall_cnt = 0;
        int first = exp_skip ? 18 : 82;
        src_q.delete();
        if (!exp_skip) for (int i = 0; i < 64; i++) src_q.push_back(wref[i]);
        for (int i = 0; i < 8; i++) src_q.push_back(xref[i]);
        nw = 0; nx = 0; en_cnt = 0; clr_cnt = 0; done_seen = 0; hold = 0; done_rel = -1;
        res_row.delete(); res_val.delete(); res_rel.delete();
        @(posedge clk); #1;
        start = 1; reuse_w = reuse; base = cyc;
        data_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'b0 : 1'($urandom % 2);
        result_ready = 1;
        for (int n = 0; n < 3000 && !done_seen; n++) begin
            @(posedge clk); #1;
            start      = busy ? 1'($urandom % 2) : 1'b0;
            reuse_w    = 1'($urandom % 2);
            data_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(cyc % 2) : 1'($urandom % 2);
            if (result_valid && int'(row_idx) == stall_row && stall_cnt < 5) begin
                result_ready = 0;
                stall_cnt++;
            end else result_ready = 1;
            if (abort && res_row.size() == 2 && en_acc) begin
                #2 rst = 0;
                #1 chk_reset_outputs("abort_rst_out");
                @(posedge clk); #1 chk_reset_outputs("abort_rst_hold");
                start = 0; data_valid = 0;
                @(posedge clk); #1 rst = 1;
                src_q.delete();
                return;
            end
        end
        if (!done_seen) chk("timeout", 0, 1);
        chk("nres", res_row.size(), 8);
        for (int i = 0; i < 8 && i < res_row.size(); i++) begin
            chk("row_idx", res_row[i], i);
            chk("result", res_val[i], exp_row(i));
            if (timed) chk("res_cycle", res_rel[i], first + 10 * i);
        end
        if (timed) chk("done_cycle", done_rel, first + 71);
        chk("w_writes", nw, exp_skip ? 0 : 64);
        chk("x_writes", nx, 8);
    endtask

    initial begin
        #3 chk_reset_outputs("reset_out");
        @(posedge clk); #1 chk_reset_outputs("reset_out2");
        rst = 1;

        for (int i = 0; i < 64; i++) wref[i] = 1;
        for (int i = 0; i < 8; i++) xref[i] = 14'(i + 1);
        run_op(0, 0, 0, -1, 1, 0);

        for (int i = 0; i < 8; i++) xref[i] = 2;
        run_op(1, 1, 0, -1, 1, 0);

        for (int i = 0; i < 64; i++) wref[i] = (i / 8 == i % 8) ? 14'sd1 : 14'sd0;
        xref = '{-14'sd3, 14'sd5, 14'sd7, -14'sd8, 14'sd0, 14'sd1, 14'sd2, 14'sd100};
        run_op(0, 0, 1, -1, 0, 0);

        for (int i = 0; i < 64; i++) wref[i] = 14'sd8191;
        for (int i = 0; i < 8; i++) xref[i] = -14'sd8192;
        run_op(0, 0, 2, -1, 0, 0);

        for (int i = 0; i < 64; i++) wref[i] = 14'($urandom);
        for (int i = 0; i < 8; i++) xref[i] = 14'($urandom);
        run_op(0, 0, 2, 3, 0, 0);

        for (int i = 0; i < 64; i++) wref[i] = 14'($urandom_range(0, 200)) - 14'sd100;
        for (int i = 0; i < 8; i++) xref[i] = 14'($urandom_range(0, 200)) - 14'sd100;
        run_op(0, 0, 0, -1, 0, 1);
        run_op(1, 0, 0, -1, 1, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
